// File: rtl/level_meter_pkg.sv
// Shared types and elaboration-time helpers for the LED level meter.
package level_meter_pkg;

  // Wide enough for up to 255 LEDs; the top truncates it to the peak_idx width.
  localparam int COUNT_W = 8;
  typedef logic [COUNT_W-1:0] count_t;

  localparam int THR_MAX_W = 64;

  // Threshold for LED idx: level must exceed step*idx for that LED to light.
  function automatic logic [THR_MAX_W-1:0] led_threshold(input longint unsigned step,
                                                         input int unsigned idx);
    return step * 64'(idx);
  endfunction

endpackage

// File: rtl/level_window_avg.sv
// Moving average over the last 2^WIN_LOG2 accepted values using a ring buffer
// and a running sum; level is registered one cycle after the sum updates.
module level_window_avg #(
  parameter int DATA_W   = 32,
  parameter int WIN_LOG2 = 3
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  output logic [DATA_W-1:0] level
);

  localparam int DEPTH = 1 << WIN_LOG2;
  localparam int SUM_W = DATA_W + WIN_LOG2;

  logic [DATA_W-1:0]   ring [DEPTH];
  logic [WIN_LOG2-1:0] wptr;
  logic [SUM_W-1:0]    sum;
  logic                sum_valid;

  always_ff @(posedge clock) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) ring[i] <= '0;
      wptr      <= '0;
      sum       <= '0;
      sum_valid <= 1'b0;
      level     <= '0;
      out_valid <= 1'b0;
    end else begin
      sum_valid <= in_valid;
      out_valid <= sum_valid;
      if (in_valid) begin
        // Oldest entry leaves the window as the new one enters.
        sum        <= sum + SUM_W'(in_data) - SUM_W'(ring[wptr]);
        ring[wptr] <= in_data;
        wptr       <= wptr + WIN_LOG2'(1);
      end
      if (sum_valid) level <= DATA_W'(sum >> WIN_LOG2);
    end
  end

endmodule

// File: rtl/level_meter.sv
// Multi-channel level meter: mono magnitude mix, windowed average, then an
// LED thermometer with peak-hold marker and optional dot display.
module level_meter
  import level_meter_pkg::*;
#(
  parameter int DATA_W       = 32,
  parameter int CHANNELS     = 2,
  parameter int WIN_LOG2     = 3,
  parameter int N_LEDS       = 26,
  parameter int STEP         = 300000,
  parameter int HOLD_SAMPLES = 4
) (
  input  logic                         clock,
  input  logic                         reset,
  input  logic                         sample_valid,
  input  logic [CHANNELS*DATA_W-1:0]   samples,
  input  logic                         dot_mode,
  input  logic                         peak_en,
  output logic [DATA_W-1:0]            level,
  output logic [N_LEDS-1:0]            lights,
  output logic [$clog2(N_LEDS+1)-1:0]  peak_idx
);

  localparam int CH_LOG2 = $clog2(CHANNELS);
  localparam int MIX_W   = DATA_W + CH_LOG2;
  localparam int THR_W   = DATA_W + $clog2(N_LEDS);
  localparam int PEAK_W  = $clog2(N_LEDS + 1);
  localparam int HOLD_W  = $clog2(HOLD_SAMPLES + 1);
  localparam logic [N_LEDS-1:0] LED_ONE = N_LEDS'(1);

  // Most negative input maps to 2^(DATA_W-1), which still fits unsigned.
  function automatic logic [DATA_W-1:0] magnitude(input logic [DATA_W-1:0] x);
    return x[DATA_W-1] ? (~x + DATA_W'(1)) : x;
  endfunction

  logic [MIX_W-1:0]  mix;
  logic [DATA_W-1:0] mono;
  logic              v1;
  logic              v2;

  always_comb begin
    mix = '0;
    for (int k = 0; k < CHANNELS; k++)
      mix = mix + MIX_W'(magnitude(samples[k*DATA_W +: DATA_W]));
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      mono <= '0;
      v1   <= 1'b0;
    end else begin
      v1 <= sample_valid;
      if (sample_valid) mono <= DATA_W'(mix >> CH_LOG2);
    end
  end

  level_window_avg #(
    .DATA_W   (DATA_W),
    .WIN_LOG2 (WIN_LOG2)
  ) u_window (
    .clock     (clock),
    .reset     (reset),
    .in_valid  (v1),
    .in_data   (mono),
    .out_valid (v2),
    .level     (level)
  );

  logic [N_LEDS-1:0] bar;
  count_t            cnt;

  always_comb begin
    bar = '0;
    cnt = '0;
    for (int i = 0; i < N_LEDS; i++) begin
      bar[i] = THR_W'(level) > THR_W'(led_threshold(longint'(STEP), i));
      cnt    = cnt + count_t'(bar[i]);
    end
  end

  count_t            peak_q, peak_d;
  logic [HOLD_W-1:0] hold_q, hold_d;
  logic [N_LEDS-1:0] lights_d;

  // Peak marker: capture on rise, hold for HOLD_SAMPLES updates, then fall one LED per update.
  always_comb begin
    peak_d = peak_q;
    hold_d = hold_q;
    if (cnt >= peak_q) begin
      peak_d = cnt;
      hold_d = HOLD_W'(HOLD_SAMPLES);
    end else if (hold_q != '0) begin
      hold_d = hold_q - HOLD_W'(1);
    end else begin
      peak_d = peak_q - count_t'(1);
    end

    lights_d = dot_mode ? '0 : bar;
    if (dot_mode && cnt != '0) lights_d = lights_d | (LED_ONE << (cnt - count_t'(1)));
    if (peak_en && peak_d != '0) lights_d = lights_d | (LED_ONE << (peak_d - count_t'(1)));
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      peak_q <= '0;
      hold_q <= '0;
      lights <= '0;
    end else if (v2) begin
      peak_q <= peak_d;
      hold_q <= hold_d;
      lights <= lights_d;
    end
  end

  assign peak_idx = PEAK_W'(peak_q);

endmodule

// File: tb/tb_level_meter.sv
// Bench for level_meter: directed and random sample streams checked against
// a sample-ordered average/peak model with acceptance-relative timing.
module tb_level_meter;

  logic         clock = 1'b0;
  logic         reset;
  logic         sample_valid;
  logic [63:0]  samples;
  logic         dot_mode;
  logic         peak_en;
  logic [31:0]  level;
  logic [25:0]  lights;
  logic [4:0]   peak_idx;

  level_meter dut (
    .clock        (clock),
    .reset        (reset),
    .sample_valid (sample_valid),
    .samples      (samples),
    .dot_mode     (dot_mode),
    .peak_en      (peak_en),
    .level        (level),
    .lights       (lights),
    .peak_idx     (peak_idx)
  );

  always #5 clock = ~clock;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  // Model state
  longint win_q[$];
  int     m_peak, m_hold;

  // Scheduled expectations: value plus the cycle it becomes visible
  int          due_lvl_q[$];
  logic [31:0] exp_level_q[$];
  int          due_led_q[$];
  logic [25:0] exp_lights_q[$];
  logic [4:0]  exp_peak_q[$];

  logic [31:0] cur_level;
  logic [25:0] cur_lights;
  logic [4:0]  cur_peak;

  task automatic model_reset();
    win_q.delete();
    repeat (8) win_q.push_back(0);
    m_peak = 0;
    m_hold = 0;
    due_lvl_q.delete();
    exp_level_q.delete();
    due_led_q.delete();
    exp_lights_q.delete();
    exp_peak_q.delete();
    cur_level  = '0;
    cur_lights = '0;
    cur_peak   = '0;
  endtask

  task automatic model_accept(input int l, input int r);
    longint a, b, mono, s, lvl, cnt;
    logic [63:0] lt;
    a = l;
    b = r;
    if (a < 0) a = -a;
    if (b < 0) b = -b;
    mono = (a + b) / 2;
    win_q.push_back(mono);
    void'(win_q.pop_front());
    s = 0;
    foreach (win_q[i]) s += win_q[i];
    lvl = s / 8;
    due_lvl_q.push_back(cyc + 2);
    exp_level_q.push_back(32'(lvl));
    // Number of LEDs whose threshold 300000*i lies strictly below the level
    cnt = (lvl == 0) ? 0 : (lvl - 1) / 300000 + 1;
    if (cnt > 26) cnt = 26;
    if (cnt >= m_peak) begin
      m_peak = int'(cnt);
      m_hold = 4;
    end else if (m_hold != 0) begin
      m_hold--;
    end else begin
      m_peak--;
    end
    if (dot_mode) lt = (cnt == 0) ? 64'd0 : (64'd1 << (cnt - 1));
    else          lt = (64'd1 << cnt) - 64'd1;
    if (peak_en && m_peak != 0) lt |= 64'd1 << (m_peak - 1);
    due_led_q.push_back(cyc + 3);
    exp_lights_q.push_back(26'(lt));
    exp_peak_q.push_back(5'(m_peak));
  endtask

  // One clock: drive inputs, take the edge, update model, check all outputs.
  task automatic step(input bit v, input int l, input int r);
    sample_valid = v;
    samples      = {r, l};
    @(posedge clock);
    cyc++;
    if (reset)  model_reset();
    else if (v) model_accept(l, r);
    #1;
    while (due_lvl_q.size() > 0 && due_lvl_q[0] <= cyc) begin
      cur_level = exp_level_q.pop_front();
      void'(due_lvl_q.pop_front());
    end
    while (due_led_q.size() > 0 && due_led_q[0] <= cyc) begin
      cur_lights = exp_lights_q.pop_front();
      cur_peak   = exp_peak_q.pop_front();
      void'(due_led_q.pop_front());
    end
    total++;
    assert (level === cur_level) else begin
      bad++;
      $error("FAIL level cyc=%0d got=%0d exp=%0d", cyc, level, cur_level);
    end
    total++;
    assert (lights === cur_lights) else begin
      bad++;
      $error("FAIL lights cyc=%0d got=%h exp=%h", cyc, lights, cur_lights);
    end
    total++;
    assert (peak_idx === cur_peak) else begin
      bad++;
      $error("FAIL peak_idx cyc=%0d got=%0d exp=%0d", cyc, peak_idx, cur_peak);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) step(1'b0, int'($urandom), int'($urandom));
  endtask

  task automatic feed_gap(input int l, input int r, input int maxgap);
    idle(int'($urandom_range(0, maxgap)));
    step(1'b1, l, r);
  endtask

  task automatic check_final(input string tag, input logic [31:0] lv, input logic [25:0] lt);
    total++;
    assert (level === lv) else begin
      bad++;
      $error("FAIL %s level got=%0d exp=%0d", tag, level, lv);
    end
    total++;
    assert (lights === lt) else begin
      bad++;
      $error("FAIL %s lights got=%h exp=%h", tag, lights, lt);
    end
  endtask

  function automatic int rand_sample();
    int unsigned sel;
    sel = $urandom_range(0, 9);
    if (sel == 0) return int'(32'h80000000);
    if (sel == 1) return 32'h7fffffff;
    if (sel < 5)  return -int'($urandom_range(0, 9000000));
    return int'($urandom_range(0, 9000000));
  endfunction

  initial begin
    reset        = 1'b1;
    sample_valid = 1'b0;
    samples      = '0;
    dot_mode     = 1'b0;
    peak_en      = 1'b0;
    model_reset();

    // Reset state
    idle(3);
    reset = 1'b0;
    idle(2);

    // Ramp: eight equal samples build the average in 75000 steps
    for (int i = 0; i < 8; i++) step(1'b1, 600000, 600000);
    idle(4);
    check_final("ramp", 32'd600000, 26'h3);

    // Opposite signs give the same magnitude trace
    reset = 1'b1;
    idle(1);
    reset = 1'b0;
    for (int i = 0; i < 8; i++) step(1'b1, -600000, 600000);
    idle(4);
    check_final("sign", 32'd600000, 26'h3);

    // Most negative value on both channels is full scale
    for (int i = 0; i < 8; i++) step(1'b1, int'(32'h80000000), int'(32'h80000000));
    idle(4);
    check_final("full", 32'h80000000, 26'h3FFFFFF);

    // Peak hold and decay while the bar collapses
    peak_en = 1'b1;
    for (int i = 0; i < 40; i++) step(1'b1, 0, 0);
    idle(4);
    check_final("decay", 32'd0, 26'h0);

    // Mid-stream reset with valid high discards samples and re-zeros the ring
    for (int i = 0; i < 5; i++) step(1'b1, rand_sample(), rand_sample());
    reset = 1'b1;
    step(1'b1, 5000000, 5000000);
    step(1'b1, 5000000, 5000000);
    reset = 1'b0;
    step(1'b1, 800000, 800000);
    idle(4);
    check_final("rst", 32'd100000, 26'h1);

    // Dot mode with gaps at full scale
    peak_en  = 1'b0;
    dot_mode = 1'b1;
    for (int i = 0; i < 8; i++) feed_gap(int'(32'h80000000), int'(32'h80000000), 5);
    idle(4);
    check_final("dot", 32'h80000000, 26'h2000000);

    // Random traffic with gaps; display modes change only when drained
    for (int blk = 0; blk < 6; blk++) begin
      dot_mode = 1'($urandom_range(0, 1));
      peak_en  = 1'($urandom_range(0, 1));
      for (int i = 0; i < 16; i++) feed_gap(rand_sample(), rand_sample(), 5);
      idle(4);
    end

    // Back-to-back random traffic with the peak marker on
    dot_mode = 1'b0;
    peak_en  = 1'b1;
    for (int i = 0; i < 40; i++) step(1'b1, rand_sample(), rand_sample());
    for (int i = 0; i < 20; i++) step(1'b1, 0, 0);
    idle(4);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/level_meter.md
# level_meter

Parametrised multi-channel audio level meter that drives an LED bar from a windowed moving average of sample magnitudes. It is the successor to the fixed two-channel 26-LED visualizer: it accepts samples on a valid strobe rather than every clock, takes signed magnitudes, and sizes the averaging window, LED count and step at elaboration. It adds a peak-hold marker and a dot display mode. It sits after the codec sample receiver, in the same clock domain, and feeds the board LEDs.

## Interface
- DATA_W, 32: sample width, signed two's complement
- CHANNELS, 2: channel count, power of two, ≥1
- WIN_LOG2, 3: averaging window = 2^WIN_LOG2 accepted samples
- N_LEDS, 26: LED count, ≥2
- STEP, 300000: level step per LED
- HOLD_SAMPLES, 4: updates the peak marker holds before decaying, ≥1
- clock  in  1  sole clock; all state changes on posedge
- reset  in  1  synchronous, active-high
- sample_valid  in  1  samples accepted on any cycle it is high
- samples  in  CHANNELS*DATA_W  channel k at bits [k*DATA_W +: DATA_W]
- dot_mode  in  1  0 = bar, 1 = single dot at top of bar
- peak_en  in  1  overlay peak-hold marker
- level  out  DATA_W  current window average, unsigned
- lights  out  N_LEDS  LED drive, bit 0 = lowest
- peak_idx  out  $clog2(N_LEDS+1)  held peak bar count, 0..N_LEDS

## Operation
- Stage 1, on sample_valid: per channel magnitude |x| as a DATA_W-bit unsigned value. The magnitude of the most negative value is 2^(DATA_W-1) and fits. Sum all channels at DATA_W+log2(CHANNELS) bits, shift right by log2(CHANNELS) to give `mono`, then register it with `v1`.
- Stage 2, on v1: the ring buffer holds 2^WIN_LOG2 entries, all zero after reset. `sum` is DATA_W+WIN_LOG2 bits and updates as sum + mono − ring[wptr]. The entry ring[wptr] is then overwritten with mono and wptr wraps modulo the window. `level` = sum >> WIN_LOG2. This stage registers `v2`.
- Stage 3, on v2:
  - Thermometer: bar[i] = (level > STEP*i), with constants computed at DATA_W+$clog2(N_LEDS) bits. bar[0] is set for any nonzero level.
  - count = number of set bar bits.
  - Peak: if count ≥ peak_idx, peak_idx ← count and hold ← HOLD_SAMPLES. Otherwise, if hold ≠ 0, hold decrements. Otherwise peak_idx decrements by 1.
  - Display: in bar mode, lights = bar. In dot mode, lights is one-hot at count−1, or zero if count = 0. If peak_en and peak_idx ≠ 0, also set lights[peak_idx−1].
- dot_mode and peak_en are sampled only at stage-3 updates. Toggling them between samples has no effect until the next v2.
- Outputs hold their value between updates. A window that has not yet filled ramps naturally from the zeroed entries.
- Reset in any cycle clears the ring, sum, wptr, v1, v2, level, lights, peak_idx and hold to 0. A sample_valid coincident with reset is discarded.

## Timing
- A sample accepted at edge t updates `level` at t+2 and `lights`/`peak_idx` at t+3.
- Full throughput: sample_valid may be high every cycle. There is no backpressure and no sample is ever dropped.
- Gaps in sample_valid freeze the pipeline contents. Stages advance only with their own valid.
- Window arithmetic never overflows at the chosen widths. There is no saturation logic.

## Structure
- The package `level_meter_pkg` holds `count_t` and an elaboration-time function that builds the STEP*i threshold array.
- One sub-module, `level_window_avg` (ring buffer, running sum, wptr), parametrised on DATA_W and WIN_LOG2 with valid in/out.
- Threshold compare, popcount, peak FSM and display mux live in the top module.

## Test plan
All scenarios use default parameters.
- Reset: hold reset 2 cycles mid-stream with sample_valid high → level=0, lights=0, peak_idx=0 on the next cycle, and the ring is re-zeroed (next sample with L=R=800000 gives level=100000).
- Ramp: L=R=600000, valid every cycle for 8 samples → level steps 75000, 150000, …, 600000. Final lights=26'h3 and count=2, with level reaching 600000 exactly 2 cycles after the 8th valid.
- Sign/full scale: L=−600000, R=600000 → identical trace to the ramp. L=R=32'h80000000 for 8 samples → level=2^31, lights=26'h3FFFFFF.
- Peak hold: fill to full scale, then feed zeros with peak_en=1 → bar shrinks over 8 samples. Bit 25 stays lit for 4 updates after the bar drops below 26, then the marker steps down one LED per update until it meets the bar or 0.
- Dot/gaps: full scale in dot_mode=1 → lights=26'h2000000. Insert random sample_valid gaps of 0–5 cycles → level and lights sequences match the gap-free run, and no output changes during gaps.
